// File: rtl/dual_issue_sched_if.sv
// rtl/dual_issue_sched_if.sv - fetch-pair input and issue-group output bundle of the dual issue scheduler
interface dual_issue_sched_if;
    logic        fetch_valid;
    logic [31:0] pc_in;
    logic [31:0] instr1_in;
    logic [31:0] instr2_in;
    logic        id_ready;
    logic        fetch_stall;
    logic [31:0] issue_pc;
    logic [31:0] issue_instr1;
    logic [31:0] issue_instr2;
    logic        issue_valid1;
    logic        issue_valid2;

    modport master (
        output fetch_valid, pc_in, instr1_in, instr2_in, id_ready,
        input  fetch_stall, issue_pc, issue_instr1, issue_instr2, issue_valid1, issue_valid2
    );

    modport slave (
        input  fetch_valid, pc_in, instr1_in, instr2_in, id_ready,
        output fetch_stall, issue_pc, issue_instr1, issue_instr2, issue_valid1, issue_valid2
    );
endinterface

// File: rtl/dual_issue_sched.sv
// rtl/dual_issue_sched.sv - pairs or splits fetched MIPS instructions into decode issue groups
module dual_issue_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    dual_issue_sched_if.slave bus,
    output logic [CNT_W-1:0] dual_cnt,
    output logic [CNT_W-1:0] split_cnt
);
    localparam logic [0:0] S_PAIR   = 1'b0;
    localparam logic [0:0] S_SECOND = 1'b1;

    logic [0:0]  state;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;

    logic [5:0]  op1, op2;
    logic [4:0]  rs2, rt2, dest1;
    logic        raw_hit, mem_conflict, ctrl1, split;

    assign op1   = bus.instr1_in[31:26];
    assign op2   = bus.instr2_in[31:26];
    assign rs2   = bus.instr2_in[25:21];
    assign rt2   = bus.instr2_in[20:16];
    assign dest1 = (op1 == 6'b000000) ? bus.instr1_in[15:11] : bus.instr1_in[20:16];

    // $0 is never a real dependency, which also keeps a nop in slot 2 from splitting
    assign raw_hit      = ((rs2 == dest1) || (rt2 == dest1)) && (dest1 != 5'd0);
    assign mem_conflict = ((op1 == 6'b100011) || (op1 == 6'b101011)) &&
                          ((op2 == 6'b100011) || (op2 == 6'b101011));
    assign ctrl1        = (op1 == 6'b000100) || (op1 == 6'b000101) ||
                          (op1 == 6'b000010) || (op1 == 6'b000011);
    assign split        = raw_hit || mem_conflict || ctrl1;

    assign bus.fetch_stall = (state == S_SECOND);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= S_PAIR;
            hold_instr       <= 32'd0;
            hold_pc          <= 32'd0;
            bus.issue_pc     <= 32'd0;
            bus.issue_instr1 <= 32'd0;
            bus.issue_instr2 <= 32'd0;
            bus.issue_valid1 <= 1'b0;
            bus.issue_valid2 <= 1'b0;
            dual_cnt         <= '0;
            split_cnt        <= '0;
        end else if (bus.id_ready) begin
            case (state)
                S_PAIR: begin
                    if (!bus.fetch_valid) begin
                        bus.issue_instr1 <= 32'd0;
                        bus.issue_instr2 <= 32'd0;
                        bus.issue_valid1 <= 1'b0;
                        bus.issue_valid2 <= 1'b0;
                    end else if (!split) begin
                        bus.issue_pc     <= bus.pc_in;
                        bus.issue_instr1 <= bus.instr1_in;
                        bus.issue_instr2 <= bus.instr2_in;
                        bus.issue_valid1 <= 1'b1;
                        bus.issue_valid2 <= 1'b1;
                        if (dual_cnt != '1)
                            dual_cnt <= dual_cnt + CNT_W'(1);
                    end else begin
                        bus.issue_pc     <= bus.pc_in;
                        bus.issue_instr1 <= bus.instr1_in;
                        bus.issue_instr2 <= 32'd0;
                        bus.issue_valid1 <= 1'b1;
                        bus.issue_valid2 <= 1'b0;
                        hold_instr       <= bus.instr2_in;
                        hold_pc          <= bus.pc_in + 32'd4;
                        state            <= S_SECOND;
                        if (split_cnt != '1)
                            split_cnt <= split_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // fetch is stalled here, so the inputs are stale and ignored
                    bus.issue_pc     <= hold_pc;
                    bus.issue_instr1 <= hold_instr;
                    bus.issue_instr2 <= 32'd0;
                    bus.issue_valid1 <= 1'b1;
                    bus.issue_valid2 <= 1'b0;
                    state            <= S_PAIR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dual_issue_sched.sv
// tb/tb_dual_issue_sched.sv - scoreboard bench for dual_issue_sched with directed vectors
module tb_dual_issue_sched;
    localparam logic [31:0] ADD3   = 32'h00221820;
    localparam logic [31:0] ADD6   = 32'h00853020;
    localparam logic [31:0] SUB7   = 32'h00643822;
    localparam logic [31:0] ADD8   = 32'h00834020;
    localparam logic [31:0] LW     = 32'h8C220000;
    localparam logic [31:0] SW     = 32'hACC50004;
    localparam logic [31:0] BEQ    = 32'h10220008;
    localparam logic [31:0] ADDI0  = 32'h20200005;
    localparam logic [31:0] ADD600 = 32'h00003020;

    typedef struct packed {
        logic        v1;
        logic        v2;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [31:0] pc;
        logic        stall;
        logic [15:0] dc;
        logic [15:0] sc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dual_cnt, split_cnt;
    logic [1:0]  sat_dual, sat_split;
    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];

    dual_issue_sched_if bus ();
    dual_issue_sched_if bus2 ();

    assign bus2.fetch_valid = bus.fetch_valid;
    assign bus2.pc_in       = bus.pc_in;
    assign bus2.instr1_in   = bus.instr1_in;
    assign bus2.instr2_in   = bus.instr2_in;
    assign bus2.id_ready    = bus.id_ready;

    dual_issue_sched #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .dual_cnt(dual_cnt), .split_cnt(split_cnt)
    );

    dual_issue_sched #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus2.slave),
        .dual_cnt(sat_dual), .split_cnt(sat_split)
    );

    always #5 clk = ~clk;

    task automatic row(input logic rst_n, input logic fv, input logic idr,
                       input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2,
                       input logic ev1, input logic ev2, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] epc, input logic est,
                       input logic [15:0] edc, input logic [15:0] esc);
        exp_t e;
        @(negedge clk);
        reset           = rst_n;
        bus.fetch_valid = fv;
        bus.id_ready    = idr;
        bus.pc_in       = pc;
        bus.instr1_in   = i1;
        bus.instr2_in   = i2;
        e = '{v1: ev1, v2: ev2, i1: e1, i2: e2, pc: epc, stall: est, dc: edc, sc: esc};
        exp_q.push_back(e);
    endtask

    // Monitor: one issue group per clock, checked just after the edge that produced it
    always @(posedge clk) begin
        exp_t e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{v1: bus.issue_valid1, v2: bus.issue_valid2, i1: bus.issue_instr1,
                  i2: bus.issue_instr2, pc: bus.issue_pc, stall: bus.fetch_stall,
                  dc: dual_cnt, sc: split_cnt};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL issue_group: got v=%b%b i1=%h i2=%h pc=%h stall=%b dual=%0d split=%0d, want v=%b%b i1=%h i2=%h pc=%h stall=%b dual=%0d split=%0d",
                         a.v1, a.v2, a.i1, a.i2, a.pc, a.stall, a.dc, a.sc,
                         e.v1, e.v2, e.i1, e.i2, e.pc, e.stall, e.dc, e.sc);
            end
        end
    end

    initial begin
        reset = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.id_ready    = 1'b0;
        bus.pc_in       = 32'd0;
        bus.instr1_in   = 32'd0;
        bus.instr2_in   = 32'd0;

        row(0,0,0, 32'h0, 0, 0,          0,0, 0, 0, 32'h0, 0, 0, 0);
        row(0,0,0, 32'h0, 0, 0,          0,0, 0, 0, 32'h0, 0, 0, 0);
        row(1,1,1, 32'h0, ADD3, ADD6,    1,1, ADD3, ADD6, 32'h0, 0, 1, 0);
        row(1,0,1, 32'h0, 0, 0,          0,0, 0, 0, 32'h0, 0, 1, 0);
        row(1,1,1, 32'h100, ADD3, SUB7,  1,0, ADD3, 0, 32'h100, 1, 1, 1);
        row(1,1,1, 32'h200, LW, SW,      1,0, SUB7, 0, 32'h104, 0, 1, 1);
        row(1,1,1, 32'h108, LW, SW,      1,0, LW, 0, 32'h108, 1, 1, 2);
        for (int k = 0; k < 3; k++)
            row(1,1,0, 32'h108, LW, SW,  1,0, LW, 0, 32'h108, 1, 1, 2);
        row(1,1,1, 32'h108, LW, SW,      1,0, SW, 0, 32'h10C, 0, 1, 2);
        row(1,1,1, 32'h110, BEQ, ADD6,   1,0, BEQ, 0, 32'h110, 1, 1, 3);
        row(1,1,1, 32'h110, BEQ, ADD6,   1,0, ADD6, 0, 32'h114, 0, 1, 3);
        row(1,1,1, 32'h118, ADDI0, ADD600, 1,1, ADDI0, ADD600, 32'h118, 0, 2, 3);
        row(1,1,1, 32'h120, ADD3, 0,     1,1, ADD3, 0, 32'h120, 0, 3, 3);
        row(1,1,0, 32'h128, LW, SW,      1,1, ADD3, 0, 32'h120, 0, 3, 3);
        row(1,1,1, 32'hFFFFFFFC, ADD3, SUB7, 1,0, ADD3, 0, 32'hFFFFFFFC, 1, 3, 4);
        row(1,0,1, 32'h0, 0, 0,          1,0, SUB7, 0, 32'h0, 0, 3, 4);
        row(1,1,1, 32'h200, LW, SW,      1,0, LW, 0, 32'h200, 1, 3, 5);
        row(0,1,1, 32'h208, ADD3, ADD6,  0,0, 0, 0, 32'h0, 0, 0, 0);
        row(1,0,1, 32'h0, 0, 0,          0,0, 0, 0, 32'h0, 0, 0, 0);
        row(1,1,1, 32'h300, ADD3, ADD6,  1,1, ADD3, ADD6, 32'h300, 0, 1, 0);
        row(1,1,1, 32'h400, ADD3, ADD8,  1,0, ADD3, 0, 32'h400, 1, 1, 1);
        row(1,1,1, 32'h400, ADD3, ADD8,  1,0, ADD8, 0, 32'h404, 0, 1, 1);
        row(1,1,1, 32'h500, ADD3, ADD6,  1,1, ADD3, ADD6, 32'h500, 0, 2, 1);
        row(1,1,1, 32'h508, ADD3, ADD6,  1,1, ADD3, ADD6, 32'h508, 0, 3, 1);
        row(1,1,1, 32'h510, ADD3, ADD6,  1,1, ADD3, ADD6, 32'h510, 0, 4, 1);
        row(1,1,1, 32'h518, ADD3, ADD6,  1,1, ADD3, ADD6, 32'h518, 0, 5, 1);
        row(1,1,1, 32'h520, ADD3, ADD6,  1,1, ADD3, ADD6, 32'h520, 0, 6, 1);

        @(negedge clk);
        bus.id_ready = 1'b0;
        repeat (3) @(negedge clk);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        tests++;
        if (sat_dual !== 2'd3) begin
            fails++;
            $display("FAIL sat_dual_cnt: got %0d, want 3", sat_dual);
        end
        tests++;
        if (sat_split !== 2'd1) begin
            fails++;
            $display("FAIL sat_split_cnt: got %0d, want 1", sat_split);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dual_issue_sched.md
Name: dual_issue_sched

Overview:
- Issue scheduler between the dual-fetch stage and the dual decode stage of the superscalar MIPS pipeline.
- Each cycle it accepts a fetched instruction pair. It either issues both together or splits them over two cycles.
- A split parks slot 2 in a hold buffer and stalls fetch, so no instruction is discarded as a nop.
- It honours downstream backpressure and keeps saturating dual/split issue counters for performance reporting.

Parameters:
- CNT_W, 16, width of the dual_cnt and split_cnt performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- fetch_valid  in  1  pc_in/instr1_in/instr2_in hold a valid fetched pair.
- pc_in  in  32  PC of instr1_in; instr2_in is at pc_in+4.
- instr1_in  in  32  older instruction of the pair.
- instr2_in  in  32  younger instruction of the pair.
- id_ready  in  1  decode stage can take a new issue group this cycle.
- fetch_stall  out  1  fetch must hold its current pair; combinational from state.
- issue_pc  out  32  PC of issue_instr1.
- issue_instr1  out  32  slot-1 instruction issued to decode.
- issue_instr2  out  32  slot-2 instruction issued to decode.
- issue_valid1  out  1  slot 1 valid.
- issue_valid2  out  1  slot 2 valid.
- dual_cnt  out  CNT_W  number of dual-issue groups; saturating.
- split_cnt  out  CNT_W  number of split pairs; saturating.

Behaviour:

Reset:
- When reset==0 at a clk edge: state=S_PAIR, hold buffer cleared.
- All issue outputs go to 0; issue_pc=0; both counters=0.
- A reset in S_SECOND drops the held instruction.

Field decode:
- opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11].
- dest1 = rd if opcode1==6'b000000, else rt.

Split condition (combinational, evaluated on the input pair). Split is any of:
- (a) RAW: (rs2==dest1 || rt2==dest1) && dest1!=0.
- (b) Both instructions are memory ops (opcode 100011 lw or 101011 sw). Only one memory port exists.
- (c) instr1 is control (opcode 000100 beq, 000101 bne, 000010 j, 000011 jal).

States:
- S_PAIR: fetch_stall=0.
- S_SECOND: fetch_stall=1.

Transitions (registered outputs; latency 1 cycle from accepted input to issue outputs):
- id_ready==0, any state: all outputs, hold buffer and state keep their values. fetch_stall is still driven from state.
- S_PAIR, id_ready=1, fetch_valid=0: issue a bubble (issue_valid1=issue_valid2=0, issue_instr1/2=0); issue_pc holds its value; stay in S_PAIR.
- S_PAIR, id_ready=1, fetch_valid=1, no split: issue_instr1/2=instr1_in/instr2_in, both valids=1, issue_pc=pc_in, dual_cnt+1; stay in S_PAIR.
- S_PAIR, id_ready=1, fetch_valid=1, split: issue_instr1=instr1_in, issue_valid1=1, issue_instr2=0, issue_valid2=0, issue_pc=pc_in. Hold buffer takes instr2_in and pc_in+4 (32-bit wrap). split_cnt+1; go to S_SECOND.
- S_SECOND, id_ready=1: issue_instr1=held instr, issue_pc=held pc, issue_valid1=1, slot 2 empty; go to S_PAIR. Fetch inputs are ignored in this state (fetch is stalled).

Pair completion:
- A fetch pair is consumed when fetch_valid && !fetch_stall && id_ready.
- After a split, fetch advances only when leaving S_SECOND.

Counters:
- Increment by 1 per event and stick at all-ones; no wrap.

Other rules:
- An all-zero instr2 (nop) never triggers RAW, because rs2=rt2=0 and dest1!=0 is required.

Test Plan:
- Independent pair: add $3,$1,$2 / add $6,$4,$5, fetch_valid=1, id_ready=1 -> next cycle both valids=1, issue_pc=pc_in, dual_cnt=1, fetch_stall=0.
- RAW split: add $3,$1,$2 / sub $7,$3,$4 at pc=0x100 -> cycle 1: slot1 add, valid2=0, fetch_stall=1, split_cnt=1; cycle 2: slot1 sub, issue_pc=0x104, fetch_stall=0.
- Structural/control: lw $2,0($1) / sw $5,4($6) -> split; beq in slot 1 -> split; addi $0 writer followed by reader of $0 -> dual issue.
- Backpressure: drop id_ready to 0 during S_SECOND for 3 cycles -> outputs and fetch_stall=1 frozen; held instr issues on the first cycle with id_ready=1.
- Reset mid-split: assert reset=0 while in S_SECOND -> next cycle all outputs 0, fetch_stall=0, counters 0; the held instruction is never issued.
- Saturation with CNT_W=2: 5 independent pairs -> dual_cnt reaches 3 and stays at 3.
